rptr_fwft_out: RTL and testbench

- Read-domain output stage placed directly downstream of the read-pointer/empty logic and the FIFO memory.
- Converts the FIFO's rinc/rempty pop interface and the memory's 1-cycle registered read data into a first-word-fall-through valid/ready stream.
- Holds popped words in a 2-entry output buffer, so backpressure never drops data and the stream sustains 1 word/cycle.

---
 rtl/rptr_fwft_out.sv | 71 +++++++
 tb/tb_rptr_fwft_out.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rptr_fwft_out.sv
// Read-domain FWFT output stage: turns rinc/rempty pops plus 1-cycle memory read
// data into a valid/ready stream through a 2-entry buffer (ent0 is always the head).
module rptr_fwft_out #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       level
);

  logic             pop_d;
  logic [1:0]       occ;
  logic [1:0]       occ_n;
  logic [1:0]       wr_idx;
  logic [DSIZE-1:0] ent0;
  logic [DSIZE-1:0] ent1;
  logic [DSIZE-1:0] ent0_n;
  logic [DSIZE-1:0] ent1_n;
  logic             deq;
  logic [2:0]       free;

  assign m_valid = (occ != 2'd0);
  assign deq     = m_valid & m_ready;
  assign free    = 3'd2 - {1'b0, occ} - {2'b0, pop_d} + {2'b0, deq};
  assign rinc    = ~rempty & (free != 3'd0);
  assign occ_n   = occ + {1'b0, pop_d} - {1'b0, deq};
  // Tail slot after this cycle's dequeue shift; only meaningful when pop_d=1.
  assign wr_idx  = occ - {1'b0, deq};

  always_comb begin
    ent0_n = ent0;
    ent1_n = ent1;
    if (deq) begin
      ent0_n = ent1;
    end
    if (pop_d) begin
      if (wr_idx == 2'd0) begin
        ent0_n = rdata;
      end else begin
        ent1_n = rdata;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_d <= 1'b0;
      occ   <= '0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      pop_d <= rinc;
      occ   <= occ_n;
      ent0  <= ent0_n;
      ent1  <= ent1_n;
    end
  end

  assign m_data = ent0;
  assign level  = occ;

  a_no_overfill: assert property (@(posedge rclk) disable iff (!rrst_n)
    (({1'b0, occ} + {2'b0, pop_d}) <= 3'd2));

endmodule

// File: tb/tb_rptr_fwft_out.sv
// Directed and randomized checks of rptr_fwft_out against a source/memory model
// and an in-order scoreboard of popped words.
module tb_rptr_fwft_out;

  logic       rclk;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] level;

  rptr_fwft_out #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  logic [7:0]  src [0:2047];
  int unsigned rd_idx = 0;
  int unsigned limit = 0;
  logic [7:0]  expq [$];
  int unsigned delivered = 0;
  bit          rnd_mode = 0;

  logic [31:0] tr_rinc;
  logic [31:0] tr_valid;
  logic        s_rinc;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [1:0]  s_level;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One rclk cycle: sample mid-cycle, then model the memory read and the empty flag.
  task automatic tick();
    logic       p;
    logic       d;
    logic [7:0] md;
    @(negedge rclk);
    p = rinc;
    d = m_valid & m_ready;
    md = m_data;
    s_rinc = rinc; s_valid = m_valid; s_data = m_data; s_level = level;
    tr_rinc  = {tr_rinc[30:0], p};
    tr_valid = {tr_valid[30:0], m_valid};
    chk("rinc_while_empty", {31'd0, p & rempty}, 32'd0);
    if (d) begin
      delivered++;
      if (expq.size() == 0) chk("deq_unexpected", 32'd1, 32'd0);
      else chk("sb_data", {24'd0, md}, {24'd0, expq.pop_front()});
    end
    @(posedge rclk);
    #1;
    if (p) begin
      rdata = src[rd_idx];
      expq.push_back(src[rd_idx]);
      rd_idx++;
    end else begin
      rdata = 8'hEE;
    end
    if (rnd_mode) begin
      m_ready = 1'($urandom_range(0, 1));
      rempty  = (rd_idx >= limit) || ($urandom_range(0, 3) == 0);
    end else begin
      rempty = (rd_idx >= limit);
    end
  endtask

  task automatic load(input int unsigned n, input logic [7:0] base);
    for (int unsigned i = 0; i < n; i++) src[rd_idx + i] = base + 8'(i);
    limit  = rd_idx + n;
    rempty = (n == 0);
  endtask

  initial begin
    rrst_n = 1'b0; rempty = 1'b1; m_ready = 1'b0; rdata = 8'h00;
    tr_rinc = '0; tr_valid = '0;
    #3;
    chk("rst_rinc", {31'd0, rinc}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    @(negedge rclk); rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_rinc", tr_rinc & 32'h7, 32'h0);
    chk("idle_valid", tr_valid & 32'h7, 32'h0);
    chk("idle_level", {30'd0, s_level}, 32'd0);

    // Single word
    m_ready = 1'b1; load(1, 8'hA5); tr_rinc = '0; tr_valid = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) chk("single_data", {24'd0, s_data}, 32'hA5);
    end
    chk("single_rinc", tr_rinc, 32'b10000);
    chk("single_valid", tr_valid, 32'b00100);
    chk("single_level", {30'd0, s_level}, 32'd0);

    // Stream of 8 words at full rate
    load(8, 8'h01); tr_rinc = '0; tr_valid = '0; delivered = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("stream_rinc", tr_rinc, 32'b1111_1111_0000);
    chk("stream_valid", tr_valid, 32'b0011_1111_1100);
    chk("stream_count", delivered, 32'd8);

    // Backpressure then release
    m_ready = 1'b0; load(6, 8'h30); tr_rinc = '0; tr_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_rinc", tr_rinc, 32'b110000);
    chk("bp_valid", tr_valid, 32'b001111);
    chk("bp_level", {30'd0, s_level}, 32'd2);
    chk("bp_hold_data", {24'd0, s_data}, 32'h30);
    m_ready = 1'b1; tr_rinc = '0; tr_valid = '0; delivered = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_rel_rinc", tr_rinc, 32'b11110000);
    chk("bp_rel_valid", tr_valid, 32'b11111100);
    chk("bp_rel_count", delivered, 32'd6);

    // Random backpressure and availability, 1000 words
    load(1000, 8'h00);
    for (int unsigned i = 0; i < 1000; i++) src[rd_idx + i] = 8'($urandom);
    rnd_mode = 1; delivered = 0;
    for (int i = 0; i < 6000 && delivered < 1000; i++) tick();
    rnd_mode = 0;
    chk("rnd_count", delivered, 32'd1000);
    m_ready = 1'b1; rempty = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rnd_drained", expq.size(), 32'd0);

    // Reset with one word buffered and one in flight
    m_ready = 1'b0; load(4, 8'h50);
    tick(); tick();
    chk("pre_rst_level", {30'd0, level}, 32'd1);
    rempty = 1'b1; rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_level", {30'd0, level}, 32'd0);
    chk("mid_rst_data", {24'd0, m_data}, 32'd0);
    expq.delete();
    @(negedge rclk); rrst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, s_valid}, 32'd0);
    m_ready = 1'b1; load(3, 8'hC0); delivered = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) chk("post_rst_first", {24'd0, s_data}, 32'hC0);
    end
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_count", delivered, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
